// File: rtl/pixel_frame_streamer_if.sv
// pixel_frame_streamer_if: raster pixel stream with valid/ready handshake and frame markers
//   master drives m_valid, m_data, m_sof, m_eol, m_eof; slave drives m_ready
interface pixel_frame_streamer_if #(
  parameter int PIX_W = 8
) ();
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;
  modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
  modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: stores a ROWS x COLS frame and replays it as a raster pixel stream
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en_i/addr/data   frame-buffer write port, honoured only while idle
//   start_i             request one raster pass
//   busy_o, done_o      pass in progress / one-cycle end-of-pass pulse
//   m_if                output pixel stream (master side)
module pixel_frame_streamer #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int PIX_W = 8,
  localparam int AW = $clog2(ROWS * COLS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [AW-1:0]                 wr_addr_i,
  input  logic [PIX_W-1:0]              wr_data_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  pixel_frame_streamer_if.master        m_if
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [1:0] IDLE = 2'd0, PREFETCH = 2'd1, STREAM = 2'd2, FINISH = 2'd3;
  localparam logic [AW:0]   NPIX     = (AW + 1)'(ROWS * COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [PIX_W-1:0] mem [ROWS*COLS];
  logic [1:0]       state_q, state_d;
  logic [AW:0]      rd_addr_q, rd_addr_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [PIX_W-1:0] out_q, out_d, skid_q, skid_d, rdata;
  logic             pop, load_out, issue, eof;

  assign busy_o = state_q != IDLE;
  assign done_o = state_q == FINISH;
  assign rdata  = mem[rd_addr_q[AW-1:0]];
  assign eof    = out_v_q && row_q == ROW_LAST && col_q == COL_LAST;

  assign m_if.m_valid = out_v_q;
  assign m_if.m_data  = out_v_q ? out_q : '0;
  assign m_if.m_sof   = out_v_q && row_q == '0 && col_q == '0;
  assign m_if.m_eol   = out_v_q && col_q == COL_LAST;
  assign m_if.m_eof   = eof;

  always_ff @(posedge clk)
    if (wr_en_i && !busy_o && {1'b0, wr_addr_i} < NPIX) mem[wr_addr_i] <= wr_data_i;

  // A read is issued whenever the skid slot is free, independent of m_ready; the
  // read data lands in the output register if it frees up on that edge, else in skid.
  always_comb begin
    pop       = out_v_q && m_if.m_ready;
    load_out  = !out_v_q || pop;
    issue     = (state_q == PREFETCH || state_q == STREAM) && rd_addr_q < NPIX && !skid_v_q;
    state_d   = state_q == IDLE     ? (start_i ? PREFETCH : IDLE) :
                state_q == PREFETCH ? STREAM :
                state_q == STREAM   ? (pop && eof ? FINISH : STREAM) : IDLE;
    rd_addr_d = state_q == IDLE ? '0 : issue ? rd_addr_q + 1'b1 : rd_addr_q;
    out_v_d   = load_out ? skid_v_q || issue : out_v_q;
    out_d     = !load_out ? out_q : skid_v_q ? skid_q : issue ? rdata : out_q;
    skid_v_d  = load_out ? 1'b0 : skid_v_q || issue;
    skid_d    = (!load_out && issue) ? rdata : skid_q;
    col_d     = !pop ? col_q : col_q == COL_LAST ? '0 : col_q + 1'b1;
    row_d     = !pop ? row_q : eof ? '0 : col_q == COL_LAST ? row_q + 1'b1 : row_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
      skid_v_q  <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_v_q   <= out_v_d;
      out_q     <= out_d;
      skid_v_q  <= skid_v_d;
      skid_q    <= skid_d;
    end
endmodule
